// File: rtl/jk_modcounter_pkg.sv
// Shared definitions for the JK modulo counter slice.
//   mode_e   : MODE input encodings (hold / up / down / parallel load)
//   jk_act_e : {J,K} action codes applied to a single JK cell
//   jk_next  : next state of one JK cell for a given action
package jk_modcounter_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_UP   = 2'b01,
    JK_DOWN = 2'b10,
    JK_LOAD = 2'b11
  } mode_e;

  // Encoded as {J,K}.
  typedef enum logic [1:0] {
    JK_ACT_HOLD   = 2'b00,
    JK_ACT_CLEAR  = 2'b01,
    JK_ACT_SET    = 2'b10,
    JK_ACT_TOGGLE = 2'b11
  } jk_act_e;

  function automatic logic jk_next(input logic q, input jk_act_e act);
    logic nq;
    nq = q;
    case (act)
      JK_ACT_HOLD:   nq = q;
      JK_ACT_CLEAR:  nq = 1'b0;
      JK_ACT_SET:    nq = 1'b1;
      JK_ACT_TOGGLE: nq = ~q;
      default:       nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop cell.
//   CLK   : rising-edge clock
//   RST_N : synchronous active-low reset, loads RV
//   J, K  : 00 hold, 01 clear, 10 set, 11 toggle
//   Q     : registered state
//   QBAR  : ~Q
module jk_cell
  import jk_modcounter_pkg::*;
#(
  parameter logic RV = 1'b0
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic J,
  input  logic K,
  output logic Q,
  output logic QBAR
);

  logic q_r;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      q_r <= RV;
    end else begin
      q_r <= jk_next(q_r, jk_act_e'({J, K}));
    end
  end

  assign Q    = q_r;
  assign QBAR = ~q_r;

endmodule

// File: rtl/jk_modcounter.sv
// Modulo-MODULUS up/down counter built from WIDTH JK cells.
//   CLK   : rising-edge clock
//   RST_N : synchronous active-low reset (Q=RESET_VAL, WRAP=0, ERR=0)
//   EN    : count/load enable, 0 = hold
//   MODE  : 00 hold, 01 up, 10 down, 11 parallel load
//   D     : parallel load data
//   Q     : count value; QBAR = ~Q
//   TC    : terminal count (combinational)
//   WRAP  : one-cycle pulse in the cycle after a wrap
//   ERR   : sticky flag, set by a load with D >= MODULUS
module jk_modcounter
  import jk_modcounter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int RESET_VAL = 0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QBAR,
  output logic             TC,
  output logic             WRAP,
  output logic             ERR
);

  if (WIDTH < 1 || MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH) ||
      RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_config
    $error("jk_modcounter: illegal WIDTH/MODULUS/RESET_VAL combination");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VEC = WIDTH'(RESET_VAL);

  mode_e            mode;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             run;
  logic             load_err;
  logic             tc;
  logic             wrap_q;
  logic             err_q;

  assign mode = mode_e'(MODE);

  assign tc = EN & (((mode == JK_UP) & (q == MAX_VAL)) |
                    ((mode == JK_DOWN) & (q == '0)));

  // Per-cell J/K selection. Counting uses the ripple-free toggle rule
  // (bit i toggles when all lower bits are 1 for up, 0 for down); wraps
  // and loads drive each cell straight to its target with set/clear.
  always_comb begin
    j        = '0;
    k        = '0;
    run      = 1'b1;
    load_err = 1'b0;
    if (EN) begin
      case (mode)
        JK_UP: begin
          if (q == MAX_VAL) begin
            j = '0;
            k = '1;
          end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
              j[i] = run;
              k[i] = run;
              run  = run & q[i];
            end
          end
        end
        JK_DOWN: begin
          if (q == '0) begin
            j = MAX_VAL;
            k = ~MAX_VAL;
          end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
              j[i] = run;
              k[i] = run;
              run  = run & ~q[i];
            end
          end
        end
        JK_LOAD: begin
          if (D > MAX_VAL) begin
            j        = MAX_VAL;
            k        = ~MAX_VAL;
            load_err = 1'b1;
          end else begin
            j = D;
            k = ~D;
          end
        end
        default: begin
          j = '0;
          k = '0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell #(
      .RV(RST_VEC[gi])
    ) u_cell (
      .CLK  (CLK),
      .RST_N(RST_N),
      .J    (j[gi]),
      .K    (k[gi]),
      .Q    (q[gi]),
      .QBAR (qbar[gi])
    );
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      wrap_q <= tc;
      err_q  <= err_q | load_err;
    end
  end

  assign Q    = q;
  assign QBAR = qbar;
  assign TC   = tc;
  assign WRAP = wrap_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_jk_modcounter.sv
module tb_jk_modcounter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [3:0] d;

  logic [3:0] q1, qb1;
  logic       tc1, wrap1, err1;
  logic [2:0] q2, qb2;
  logic       tc2, wrap2, err2;

  always #5 clk = ~clk;

  jk_modcounter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut (
    .CLK(clk), .RST_N(rst_n), .EN(en), .MODE(mode), .D(d),
    .Q(q1), .QBAR(qb1), .TC(tc1), .WRAP(wrap1), .ERR(err1)
  );

  jk_modcounter #(.WIDTH(3), .MODULUS(8), .RESET_VAL(5)) dut2 (
    .CLK(clk), .RST_N(rst_n), .EN(en), .MODE(mode), .D(d[2:0]),
    .Q(q2), .QBAR(qb2), .TC(tc2), .WRAP(wrap2), .ERR(err2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit live  = 1'b0;

  // Reference state per instance: index 0 = dut, 1 = dut2.
  int mq[2];
  int mw[2];
  int me[2];
  int modv[2] = '{10, 8};
  int rvv[2]  = '{0, 5};
  int mask[2] = '{15, 7};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_tc(input int x);
    if (!en) return 0;
    if (mode == 2'b01 && mq[x] == modv[x] - 1) return 1;
    if (mode == 2'b10 && mq[x] == 0) return 1;
    return 0;
  endfunction

  task automatic model_step();
    int dv;
    for (int x = 0; x < 2; x++) begin
      dv = int'(d) & mask[x];
      if (!rst_n) begin
        mq[x] = rvv[x];
        mw[x] = 0;
        me[x] = 0;
      end else if (!en || mode == 2'b00) begin
        mw[x] = 0;
      end else if (mode == 2'b01) begin
        mw[x] = (mq[x] == modv[x] - 1) ? 1 : 0;
        mq[x] = (mq[x] + 1) % modv[x];
      end else if (mode == 2'b10) begin
        mw[x] = (mq[x] == 0) ? 1 : 0;
        mq[x] = (mq[x] + modv[x] - 1) % modv[x];
      end else begin
        mw[x] = 0;
        if (dv < modv[x]) begin
          mq[x] = dv;
        end else begin
          mq[x] = modv[x] - 1;
          me[x] = 1;
        end
      end
    end
    if (!rst_n) live = 1'b1;
  endtask

  task automatic cycle(input logic r, input logic e, input logic [1:0] m, input logic [3:0] dd);
    rst_n = r;
    en    = e;
    mode  = m;
    d     = dd;
    #1;
    if (live) begin
      chk("tc_a", 32'(tc1), 32'(exp_tc(0)));
      chk("tc_b", 32'(tc2), 32'(exp_tc(1)));
    end
    @(posedge clk);
    model_step();
    #1;
    chk("q_a",    32'(q1),    32'(mq[0]));
    chk("qbar_a", 32'(qb1),   32'((~mq[0]) & mask[0]));
    chk("wrap_a", 32'(wrap1), 32'(mw[0]));
    chk("err_a",  32'(err1),  32'(me[0]));
    chk("q_b",    32'(q2),    32'(mq[1]));
    chk("qbar_b", 32'(qb2),   32'((~mq[1]) & mask[1]));
    chk("wrap_b", 32'(wrap2), 32'(mw[1]));
    chk("err_b",  32'(err2),  32'(me[1]));
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 2'b00;
    d     = '0;

    // Reset, including reset with an active up-count request.
    cycle(1'b0, 1'b0, 2'b00, 4'd0);
    chk("rst_q_a", 32'(q1), 32'd0);
    chk("rst_qbar_a", 32'(qb1), 32'hF);
    chk("rst_q_b", 32'(q2), 32'd5);
    cycle(1'b0, 1'b1, 2'b01, 4'd0);
    chk("rst_hold_q_a", 32'(q1), 32'd0);

    // Up through a full modulus-10 lap.
    repeat (10) cycle(1'b1, 1'b1, 2'b01, 4'd0);
    chk("lap_q_a", 32'(q1), 32'd0);
    chk("lap_wrap_a", 32'(wrap1), 32'd1);

    // Load 0 then count down through the wrap.
    cycle(1'b1, 1'b1, 2'b11, 4'd0);
    cycle(1'b1, 1'b1, 2'b10, 4'd0);
    chk("down_wrap_q_a", 32'(q1), 32'd9);
    chk("down_wrap_a", 32'(wrap1), 32'd1);
    repeat (4) cycle(1'b1, 1'b1, 2'b10, 4'd0);

    // In-range and out-of-range loads, then the error stays sticky.
    cycle(1'b1, 1'b1, 2'b11, 4'd5);
    chk("load5_q_a", 32'(q1), 32'd5);
    cycle(1'b1, 1'b1, 2'b11, 4'd12);
    chk("load12_q_a", 32'(q1), 32'd9);
    chk("load12_err_a", 32'(err1), 32'd1);
    repeat (3) cycle(1'b1, 1'b1, 2'b01, 4'd0);
    chk("sticky_err_a", 32'(err1), 32'd1);
    chk("after_up_q_a", 32'(q1), 32'd2);

    // Hold via EN=0 and MODE=00, then a mid-count reset.
    cycle(1'b1, 1'b1, 2'b11, 4'd4);
    repeat (2) cycle(1'b1, 1'b1, 2'b01, 4'd0);
    repeat (3) cycle(1'b1, 1'b0, 2'b01, 4'd0);
    chk("en_hold_q_a", 32'(q1), 32'd6);
    repeat (2) cycle(1'b1, 1'b1, 2'b00, 4'd0);
    cycle(1'b1, 1'b1, 2'b01, 4'd0);
    cycle(1'b0, 1'b1, 2'b01, 4'd0);
    chk("midrst_q_a", 32'(q1), 32'd0);
    chk("midrst_err_a", 32'(err1), 32'd0);

    // Randomized traffic with occasional resets.
    repeat (400) begin
      cycle(($urandom_range(0, 24) != 0), ($urandom_range(0, 4) != 0),
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
